// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives the active-low S/R inputs of an async latch cell
// with fixed-width pulses, then reads Q back through a 2-flop synchronizer.
module sr_latch_driver #(
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 2,
    parameter int GAP_CYC    = 2,
    parameter int CW         = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic ReqValid,
    input  logic ReqSet,
    output logic ReqReady,
    output logic S_n,
    output logic R_n,
    input  logic Q,
    output logic Busy,
    output logic Done,
    output logic Err
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        GAP
    } state_t;

    localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          op;
    logic          op_nx;
    logic          q_meta;
    logic          q_sync;
    logic          accept;
    logic          last;
    logic          s_n_nx;
    logic          r_n_nx;
    logic          ready_nx;
    logic          done_nx;
    logic          err_nx;

    // ReqReady is only ever high while the FSM sits in IDLE
    assign accept = ReqValid & ReqReady;
    assign last   = (cnt == '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = PULSE;
                    cnt_nx   = PULSE_LD;
                    op_nx    = ReqSet;
                end
            end
            PULSE: begin
                if (last) begin
                    state_nx = SETTLE;
                    cnt_nx   = SETTLE_LD;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            SETTLE: begin
                if (last) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LD;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            GAP: begin
                if (last) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // S_n and R_n decode from one op bit, so both can never be low together
    always_comb begin
        s_n_nx   = ~((state == PULSE) & op);
        r_n_nx   = ~((state == PULSE) & ~op);
        ready_nx = (state == IDLE) & ~accept;
        done_nx  = (state == GAP) & (cnt == GAP_LD);
        err_nx   = done_nx & (q_sync != op);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op    <= op_nx;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q_meta <= 1'b0;
            q_sync <= 1'b0;
        end else begin
            q_meta <= Q;
            q_sync <= q_meta;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            S_n      <= 1'b1;
            R_n      <= 1'b1;
            ReqReady <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
        end else begin
            S_n      <= s_n_nx;
            R_n      <= r_n_nx;
            ReqReady <= ready_nx;
            Busy     <= ~ready_nx;
            Done     <= done_nx;
            Err      <= err_nx;
        end
    end

endmodule
